vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.
- Drives the hCount, vCount and bright inputs of the calculator display renderer, and the hSync/vSync board pins.
- Also produces the per-frame and slow update ticks that pace the renderer's state updates.
- Sits between the top level and the calculator display/renderer block.

---
 rtl/vga_timing_if.sv | 24 ++
 rtl/vga_timing_gen.sv | 94 +++++++++
 tb/tb_vga_timing_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
`timescale 1ns/1ps
// vga_timing_if: raster bundle carried from the timing generator to the display renderer.
// Latency: n/a (wires only).
// Backpressure: none; the master free-runs and the slave samples on pix_en.
// Ports: hCount/vCount raster position, hSync/vSync active-low syncs, bright visible-area flag,
//        pix_en per-pixel strobe, frame_tick per-frame strobe, slow_tick every SLOW_FRAMES frames.
interface vga_timing_if;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       pix_en;
  logic       frame_tick;
  logic       slow_tick;

  modport master (
    output hCount, vCount, hSync, vSync, bright, pix_en, frame_tick, slow_tick
  );

  modport slave (
    input hCount, vCount, hSync, vSync, bright, pix_en, frame_tick, slow_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: 640x480@60 raster timing (counts, syncs, bright) plus pixel/frame/slow strobes.
// Latency: all outputs registered; syncs/bright decode the next-state counts so they align with the counts.
// Backpressure: none; free-running, consumers must keep pace with pix_en.
// Ports: clk board clock; rst async active-low; vga (master) carries hCount, vCount, hSync, vSync,
//        bright, pix_en, frame_tick, slow_tick.
module vga_timing_gen #(
  parameter int unsigned DIV         = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 515,
  parameter int unsigned SLOW_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);
  localparam int unsigned DW = $clog2(DIV);
  localparam int unsigned FW = (SLOW_FRAMES > 1) ? $clog2(SLOW_FRAMES) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SLOW_FRAMES - 1);
  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_SYNC_W   = 10'(H_SYNC);
  localparam logic [9:0]    V_SYNC_W   = 10'(V_SYNC);
  localparam logic [9:0]    H_AS       = 10'(H_ACT_START);
  localparam logic [9:0]    H_AE       = 10'(H_ACT_END);
  localparam logic [9:0]    V_AS       = 10'(V_ACT_START);
  localparam logic [9:0]    V_AE       = 10'(V_ACT_END);

  logic [DW-1:0] div_cnt;
  logic [FW-1:0] frame_cnt;
  logic          pix_adv;
  logic          frame_wrap;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;

  assign pix_adv = (div_cnt == DIV_LAST);

  // Next raster position; frame_wrap marks the step from the last pixel back to (0,0).
  always_comb begin
    h_nxt      = vga.hCount;
    v_nxt      = vga.vCount;
    frame_wrap = 1'b0;
    if (pix_adv) begin
      if (vga.hCount == H_LAST) begin
        h_nxt = '0;
        if (vga.vCount == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = vga.vCount + 10'd1;
        end
      end else begin
        h_nxt = vga.hCount + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt        <= '0;
      frame_cnt      <= '0;
      vga.hCount     <= '0;
      vga.vCount     <= '0;
      vga.hSync      <= 1'b0;
      vga.vSync      <= 1'b0;
      vga.bright     <= 1'b0;
      vga.pix_en     <= 1'b0;
      vga.frame_tick <= 1'b0;
      vga.slow_tick  <= 1'b0;
    end else begin
      div_cnt        <= pix_adv ? '0 : div_cnt + DW'(1);
      vga.hCount     <= h_nxt;
      vga.vCount     <= v_nxt;
      // Decoding next-state counts keeps sync/bright in the same cycle as the counts.
      vga.hSync      <= (h_nxt >= H_SYNC_W);
      vga.vSync      <= (v_nxt >= V_SYNC_W);
      vga.bright     <= (h_nxt >= H_AS) && (h_nxt < H_AE) && (v_nxt >= V_AS) && (v_nxt < V_AE);
      vga.pix_en     <= pix_adv;
      vga.frame_tick <= frame_wrap;
      vga.slow_tick  <= frame_wrap && (frame_cnt == FRAME_LAST);
      if (frame_wrap) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FW'(1);
      end
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// tb_vga_timing_gen: checks three generator instances (default timing, a scaled-down raster,
// and the scaled raster with one frame per slow tick) against a closed-form raster model.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   t   = 0;     // rising edges since reset release
  int   checks = 0;
  int   errors = 0;
  int   d_hs_low = 0;
  int   s_vs_low = 0;
  int   last_ft = -1;

  always #5 clk = ~clk;

  vga_timing_if d_if ();
  vga_timing_if s_if ();
  vga_timing_if s1_if ();

  vga_timing_gen u_d (.clk(clk), .rst(rst), .vga(d_if));

  vga_timing_gen #(
    .DIV(3), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(10), .SLOW_FRAMES(4)
  ) u_s (.clk(clk), .rst(rst), .vga(s_if));

  vga_timing_gen #(
    .DIV(3), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
    .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(10), .SLOW_FRAMES(1)
  ) u_s1 (.clk(clk), .rst(rst), .vga(s1_if));

  always @(posedge clk or negedge rst) begin
    if (!rst) t <= 0;
    else      t <= t + 1;
  end

  // Outputs as a pure function of elapsed edges: pixel index p = t/DIV walks the raster.
  // Packed as {h[9:0], v[9:0], hSync, vSync, bright, pix_en, frame_tick, slow_tick}.
  function automatic logic [25:0] model(input int tt, input int dv, input int ht, input int hs,
                                        input int has, input int hae, input int vt, input int vs,
                                        input int vas, input int vae, input int sf);
    int p, h, v, fr;
    logic pe, ft, st, hsy, vsy, br;
    p   = tt / dv;
    h   = p % ht;
    v   = (p / ht) % vt;
    fr  = p / (ht * vt);
    pe  = (tt > 0) && (tt % dv == 0);
    ft  = pe && (p % (ht * vt) == 0);
    st  = ft && (fr % sf == 0);
    hsy = (h >= hs);
    vsy = (v >= vs);
    br  = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
    return {10'(h), 10'(v), hsy, vsy, br, pe, ft, st};
  endfunction

  function automatic logic [25:0] pack_d();
    return {d_if.hCount, d_if.vCount, d_if.hSync, d_if.vSync, d_if.bright,
            d_if.pix_en, d_if.frame_tick, d_if.slow_tick};
  endfunction
  function automatic logic [25:0] pack_s();
    return {s_if.hCount, s_if.vCount, s_if.hSync, s_if.vSync, s_if.bright,
            s_if.pix_en, s_if.frame_tick, s_if.slow_tick};
  endfunction
  function automatic logic [25:0] pack_s1();
    return {s1_if.hCount, s1_if.vCount, s1_if.hSync, s1_if.vSync, s1_if.bright,
            s1_if.pix_en, s1_if.frame_tick, s1_if.slow_tick};
  endfunction

  task automatic cmp_vec(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got h=%0d v=%0d hs/vs/br/pe/ft/st=%b required h=%0d v=%0d hs/vs/br/pe/ft/st=%b",
               name, t, act[25:16], act[15:6], act[5:0], exp[25:16], exp[15:6], exp[5:0]);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0d required %0d", name, t, act, exp);
    end
  endtask

  // Every-cycle compare against the model, plus frame spacing and sync-width measurements.
  always @(negedge clk) begin
    if ($time > 2) begin
      cmp_vec("d_outputs",  pack_d(),  model(t, 4, 800, 96, 144, 784, 525, 2, 35, 515, 4));
      cmp_vec("s_outputs",  pack_s(),  model(t, 3, 20, 3, 5, 17, 12, 2, 3, 10, 4));
      cmp_vec("s1_outputs", pack_s1(), model(t, 3, 20, 3, 5, 17, 12, 2, 3, 10, 1));
      if (!rst) begin
        last_ft = -1;
      end else begin
        if (t < 3200 && !d_if.hSync) d_hs_low++;
        if (t < 720 && !s_if.vSync)  s_vs_low++;
        if (s_if.frame_tick) begin
          if (last_ft < 0) lit("s_first_tick_after_release", t, 720);
          else             lit("s_frame_tick_spacing", t - last_ft, 720);
          last_ft = t;
        end
      end
    end
  end

  task automatic at_t(input int n);
    int guard;
    guard = 0;
    while (t < n && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (t != n) begin
      checks++;
      errors++;
      $display("FAIL wait_for_t got %0d required %0d", t, n);
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset_d_all_zero", int'(pack_d()), 0);
    lit("reset_s_all_zero", int'(pack_s()), 0);
    release_rst();

    at_t(3);    lit("d_pix_en_before_4th_edge", d_if.pix_en, 0);
                lit("d_hcount_before_4th_edge", d_if.hCount, 0);
    at_t(4);    lit("d_pix_en_4th_edge", d_if.pix_en, 1);
                lit("d_hcount_4th_edge", d_if.hCount, 1);
    at_t(5);    lit("d_pix_en_one_clk", d_if.pix_en, 0);
    at_t(135);  lit("s_bright_h5_v2", s_if.bright, 0);
    at_t(194);  lit("s_bright_h4_v3", s_if.bright, 0);
                lit("s_hcount_h4", s_if.hCount, 4);
    at_t(195);  lit("s_bright_h5_v3", s_if.bright, 1);
                lit("s_vcount_v3", s_if.vCount, 3);
    at_t(383);  lit("d_hsync_h95", d_if.hSync, 0);
    at_t(384);  lit("d_hsync_h96", d_if.hSync, 1);
    at_t(588);  lit("s_bright_h16_v9", s_if.bright, 1);
    at_t(591);  lit("s_bright_h17_v9", s_if.bright, 0);
    at_t(615);  lit("s_bright_h5_v10", s_if.bright, 0);
    at_t(719);  lit("s_frame_tick_before", s_if.frame_tick, 0);
    at_t(720);  lit("s_frame_tick", s_if.frame_tick, 1);
                lit("s_slow_tick_frame1", s_if.slow_tick, 0);
                lit("s1_slow_tick_frame1", s1_if.slow_tick, 1);
                lit("s_vsync_low_clks", s_vs_low, 120);
    at_t(721);  lit("s_frame_tick_after", s_if.frame_tick, 0);
    at_t(2880); lit("s_slow_tick_frame4", s_if.slow_tick, 1);
    at_t(3199); lit("d_hcount_799", d_if.hCount, 799);
                lit("d_vcount_0", d_if.vCount, 0);
    at_t(3200); lit("d_hcount_wrap", d_if.hCount, 0);
                lit("d_vcount_1", d_if.vCount, 1);
                lit("d_hsync_low_clks", d_hs_low, 384);

    // Random mid-frame async resets; the drop lands between clock edges.
    for (int ep = 0; ep < 6; ep++) begin
      repeat ($urandom_range(50, 1500)) @(negedge clk);
      @(posedge clk);
      #($urandom_range(1, 3)) rst = 1'b0;
      #1;
      lit("async_clear_d", int'(pack_d()), 0);
      lit("async_clear_s", int'(pack_s()), 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
      release_rst();
    end
    repeat (3000) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
